// File: rtl/regfile_dbg_pkg.sv
// Shared definitions for the register-file dump reader: state encoding and
// default widths matching the MIPS register file.
package regfile_dbg_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_DONE  = 2'd3
    } dump_state_e;

endpackage

// File: rtl/regfile_dump_reader.sv
// Sweeps a (possibly wrapping) address range of the register file through its
// combinational read port and streams each word out on a valid/ready
// interface. While a word waits in the output register, the read port is
// already pointed at the next address. That lets a handshake reload the
// output register in the same edge, giving one word per cycle with no bubbles.
module regfile_dump_reader
    import regfile_dbg_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] first_addr,
    input  logic [ADDR_WIDTH-1:0] last_addr,
    output logic [ADDR_WIDTH-1:0] rf_addr,
    input  logic [DATA_WIDTH-1:0] rf_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    dump_state_e           r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_addr, r_last;
    logic [ADDR_WIDTH-1:0] w_addr_inc, w_rf_addr;
    logic                  w_accept;
    logic                  w_busy, w_done;
    logic                  r_out_valid, r_out_last;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [ADDR_WIDTH-1:0] r_out_addr;

    // Address arithmetic wraps modulo 2**ADDR_WIDTH by truncation.
    assign w_addr_inc = r_addr + 1'b1;
    assign w_accept   = r_out_valid && out_ready;

    assign rf_addr   = w_rf_addr;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_addr  = r_out_addr;
    assign out_last  = r_out_last;
    assign busy      = w_busy;
    assign done      = w_done;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Next state, read-port address and status flags.
    always_comb begin
        w_next    = r_state;
        w_rf_addr = '0;
        w_busy    = 1'b0;
        w_done    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) w_next = ST_FETCH;
            end
            ST_FETCH: begin
                w_rf_addr = r_addr;
                w_busy    = 1'b1;
                w_next    = ST_SEND;
            end
            ST_SEND: begin
                // Look one word ahead so a handshake can reload immediately.
                w_rf_addr = w_addr_inc;
                w_busy    = 1'b1;
                if (w_accept && r_out_last) w_next = ST_DONE;
            end
            ST_DONE: begin
                w_done = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Range latch, address walk and output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr      <= '0;
            r_last      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_addr  <= '0;
            r_out_last  <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_addr <= first_addr;
                        r_last <= last_addr;
                    end
                end
                ST_FETCH: begin
                    r_out_data  <= rf_data;
                    r_out_addr  <= r_addr;
                    r_out_last  <= (r_addr == r_last);
                    r_out_valid <= 1'b1;
                end
                ST_SEND: begin
                    if (w_accept) begin
                        if (r_out_last) begin
                            r_out_valid <= 1'b0;
                        end else begin
                            r_addr     <= w_addr_inc;
                            r_out_data <= rf_data;
                            r_out_addr <= w_addr_inc;
                            r_out_last <= (w_addr_inc == r_last);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench: stimulus pushes expected beats, a negedge monitor pops
// and compares each accepted beat, checks stall stability and done timing.
module tb_regfile_dump_reader;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  first_addr = '0;
    logic [4:0]  last_addr = '0;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [4:0]  out_addr;
    logic        out_last;
    logic        busy;
    logic        done;

    // Register file write port, driven as the core would.
    logic        we3 = 1'b0;
    logic [4:0]  A3 = '0;
    logic [31:0] WD3 = '0;
    logic [31:0] rf_mem [32];

    int    n_tests = 0;
    int    n_fail  = 0;
    int    nbeats  = 0;
    int    cyc     = 0;
    beat_t sb [$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Register file: synchronous write, asynchronous read.
    always_ff @(posedge clk) if (we3) rf_mem[A3] <= WD3;
    assign rf_data = rf_mem[rf_addr];

    regfile_dump_reader #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .start(start),
        .first_addr(first_addr), .last_addr(last_addr),
        .rf_addr(rf_addr), .rf_data(rf_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_addr(out_addr), .out_last(out_last),
        .busy(busy), .done(done)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beat(input logic [4:0] a, input logic [31:0] d, input logic l);
        beat_t b;
        b.addr = a; b.data = d; b.last = l;
        sb.push_back(b);
    endtask

    // Expected beats for a range holding the preload pattern.
    task automatic push_range(input logic [4:0] f, input logic [4:0] l);
        logic [4:0] a;
        a = f;
        forever begin
            push_beat(a, 32'h1000_0000 + 32'(a), a == l);
            if (a == l) break;
            a = a + 5'd1;
        end
    endtask

    task automatic start_dump(input logic [4:0] f, input logic [4:0] l);
        start = 1'b1; first_addr = f; last_addr = l;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int at);
        at = -1;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (done) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) chk("done_timeout", 64'd0, 64'd1);
    endtask

    // Monitor: compares accepted beats, stall stability and the done pulse.
    logic        prev_stall = 1'b0;
    logic        done_exp = 1'b0;
    logic [31:0] p_data;
    logic [4:0]  p_addr;
    logic        p_last;
    always @(negedge clk) begin
        beat_t e;
        if (!rst) begin
            if (prev_stall)
                chk("stall_stable", {out_valid, out_addr, out_data, out_last},
                    {1'b1, p_addr, p_data, p_last});
            if (out_valid && out_ready) begin
                nbeats++;
                if (sb.size() == 0) begin
                    chk("unexpected_beat", {out_addr, out_data, out_last}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("beat", {out_addr, out_data, out_last}, {e.addr, e.data, e.last});
                end
            end
            if (done || done_exp) chk("done_pulse", done, done_exp);
            done_exp   = out_valid && out_ready && out_last;
            prev_stall = out_valid && !out_ready;
            p_data = out_data; p_addr = out_addr; p_last = out_last;
        end else begin
            prev_stall = 1'b0;
            done_exp   = 1'b0;
        end
    end

    initial begin
        int c, at, b0;

        // Reset state.
        #2;
        chk("reset_outs", {out_valid, out_data, out_addr, out_last, busy, done, rf_addr}, 64'd0);
        tick(); tick();
        rst = 1'b0;

        // Preload reg[i] = 0x1000_0000 + i via the write port.
        for (int i = 0; i < 32; i++) begin
            we3 = 1'b1; A3 = 5'(i); WD3 = 32'h1000_0000 + i;
            tick();
        end
        we3 = 1'b0;
        tick();

        // Full sweep 0..31, sink always ready.
        out_ready = 1'b1;
        b0 = nbeats;
        c = cyc;
        push_range(5'd0, 5'd31);
        start_dump(5'd0, 5'd31);
        chk("fetch_no_valid", {busy, out_valid}, {1'b1, 1'b0});
        tick();
        chk("first_valid_lat", {out_valid, out_addr}, {1'b1, 5'd0});
        wait_done(60, at);
        chk("sweep_done_cycle", at - c, 34);
        chk("busy_low_in_done", busy, 1'b0);
        chk("sweep_beats", nbeats - b0, 32);
        tick();

        // Wrapping range 30..1 with ready toggling.
        b0 = nbeats;
        push_range(5'd30, 5'd1);
        start_dump(5'd30, 5'd1);
        for (int k = 0; k < 40; k++) begin
            out_ready = (k % 2 == 0);
            @(negedge clk);
            if (done) break;
            @(posedge clk); #1;
        end
        chk("wrap_beats", nbeats - b0, 4);
        tick();
        out_ready = 1'b1;

        // Single-word range 7..7.
        b0 = nbeats;
        push_range(5'd7, 5'd7);
        start_dump(5'd7, 5'd7);
        wait_done(10, at);
        chk("single_beats", nbeats - b0, 1);
        tick();

        // Concurrent write to reg 5 on its capture edge: old value is streamed.
        out_ready = 1'b0;
        push_beat(5'd4, 32'h1000_0004, 1'b0);
        push_beat(5'd5, 32'h1000_0005, 1'b0);
        push_beat(5'd6, 32'h1000_0006, 1'b1);
        start_dump(5'd4, 5'd6);
        tick(); tick(); tick();
        out_ready = 1'b1; we3 = 1'b1; A3 = 5'd5; WD3 = 32'hDEAD_BEEF;
        tick();
        we3 = 1'b0; out_ready = 1'b0;
        tick(); tick();
        out_ready = 1'b1;
        wait_done(20, at);
        tick();
        push_beat(5'd5, 32'hDEAD_BEEF, 1'b1);
        start_dump(5'd5, 5'd5);
        wait_done(10, at);
        tick();

        // Start while busy is ignored.
        b0 = nbeats;
        push_range(5'd10, 5'd13);
        start_dump(5'd10, 5'd13);
        tick();
        start = 1'b1; first_addr = 5'd20; last_addr = 5'd25;
        tick();
        start = 1'b0;
        wait_done(20, at);
        chk("ignore_start_beats", nbeats - b0, 4);
        tick(); tick();
        chk("ignore_start_idle", {busy, out_valid}, 2'b00);

        // Reset mid-dump.
        out_ready = 1'b0;
        start_dump(5'd8, 5'd15);
        tick();
        chk("pre_reset_valid", {out_valid, out_addr}, {1'b1, 5'd8});
        #2 rst = 1'b1;
        #1;
        chk("mid_reset_outs", {out_valid, out_data, out_addr, out_last, busy, done}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("no_done_after_reset", {done, busy}, 2'b00);
        end
        tick();
        out_ready = 1'b1;
        b0 = nbeats;
        push_range(5'd2, 5'd3);
        start_dump(5'd2, 5'd3);
        wait_done(10, at);
        chk("post_reset_beats", nbeats - b0, 2);
        tick();
        chk("scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
